// File: rtl/pwm_capture.sv
// pwm_capture: Wishbone-slave PWM decoder. It measures the period and the high
// time of an asynchronous pulse train in bus-clock cycles, flags stuck-line and
// counter-overflow events, and streams the high time out as a duty-cycle word
// with a one-cycle valid strobe.
// Optional build macro PWM_CAPTURE_IRQ_EN adds o_int and ctrl bit3 irq_enable.
module pwm_capture #(
  parameter int SYNC_STAGES = 2,
  parameter int CW          = 16
) (
  input  logic          i_wb_clk,
  input  logic          i_wb_rst_n,
  input  logic          i_wb_cyc,
  input  logic          i_wb_stb,
  input  logic          i_wb_we,
  input  logic [15:0]   i_wb_adr,
  input  logic [15:0]   i_wb_data,
  output logic [15:0]   o_wb_data,
  output logic          o_wb_ack,
`ifdef PWM_CAPTURE_IRQ_EN
  output logic          o_int,
`endif
  input  logic          i_pwm,
  output logic [15:0]   o_DC,
  output logic          o_valid_DC
);

  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CW-1:0]          cnt_q, cnt_d, hcnt_q, hcnt_d;
  logic [CW-1:0]          period_q, period_d, high_q, high_d, tmo_q, tmo_d;
  logic [15:0]            dc_q, dc_d;
  logic                   vdc_q, vdc_d;
  logic                   en_q, en_d, cont_q, cont_d, inv_q, inv_d, srst_q, srst_d;
  logic                   valid_q, valid_d, ovf_q, ovf_d, stuck_q, stuck_d;
  logic                   slvl_q, slvl_d;
  logic                   irq_bit;

  logic lvl_raw, lvl, rise, fall, bus, wr, wr_ctrl, wr_stat, wr_tmo;

  // Input conditioning: the synchronizer tail, optional inversion, edge detect.
  assign lvl_raw = sync_q[SYNC_STAGES-1];
  assign lvl     = lvl_raw ^ inv_q;
  assign rise    = lvl & ~prev_q;
  assign fall    = ~lvl & prev_q;

  assign bus      = i_wb_cyc & i_wb_stb;
  assign wr       = bus & i_wb_we;
  assign wr_ctrl  = wr && (i_wb_adr == 16'h0000);
  assign wr_stat  = wr && (i_wb_adr == 16'h0002);
  assign wr_tmo   = wr && (i_wb_adr == 16'h0008);
  assign o_wb_ack = bus;
  assign o_DC       = dc_q;
  assign o_valid_DC = vdc_q;

`ifdef PWM_CAPTURE_IRQ_EN
  logic irq_en_q, irq_en_d, int_q, int_d;
  assign irq_bit = irq_en_q;
  assign o_int   = int_q;
`else
  assign irq_bit = 1'b0;
`endif

  // Register read mux; unmapped addresses return zero.
  always_comb begin
    o_wb_data = 16'h0000;
    case (i_wb_adr)
      16'h0000: o_wb_data = {8'h00, srst_q, 3'b000, irq_bit, inv_q, cont_q, en_q};
      16'h0002: o_wb_data = {12'h000, slvl_q, stuck_q, ovf_q, valid_q};
      16'h0004: o_wb_data = period_q;
      16'h0006: o_wb_data = high_q;
      16'h0008: o_wb_data = tmo_q;
      default:  o_wb_data = 16'h0000;
    endcase
  end

  // Next state: bus writes first, then the measurement FSM, so hardware
  // status sets and the one-shot enable clear override a same-cycle write.
  always_comb begin
    state_d  = state_q;
    sync_d   = {sync_q[SYNC_STAGES-2:0], i_pwm};
    prev_d   = lvl;
    cnt_d    = cnt_q;
    hcnt_d   = hcnt_q;
    period_d = period_q;
    high_d   = high_q;
    tmo_d    = tmo_q;
    dc_d     = dc_q;
    vdc_d    = 1'b0;
    en_d     = en_q;
    cont_d   = cont_q;
    inv_d    = inv_q;
    srst_d   = 1'b0;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    stuck_d  = stuck_q;
    slvl_d   = slvl_q;
`ifdef PWM_CAPTURE_IRQ_EN
    irq_en_d = irq_en_q;
    int_d    = irq_en_q & (valid_q | ovf_q | stuck_q);
`endif

    if (wr_ctrl) begin
      en_d   = i_wb_data[0];
      cont_d = i_wb_data[1];
      inv_d  = i_wb_data[2];
`ifdef PWM_CAPTURE_IRQ_EN
      irq_en_d = i_wb_data[3];
`endif
    end
    if (wr_tmo) tmo_d = i_wb_data[CW-1:0];
    if (wr_stat) begin
      valid_d = valid_q & ~i_wb_data[0];
      ovf_d   = ovf_q   & ~i_wb_data[1];
      stuck_d = stuck_q & ~i_wb_data[2];
    end

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en_q) state_d = ARM;
      end
      ARM: begin
        if (!en_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (rise) begin
          cnt_d   = {{(CW-1){1'b0}}, 1'b1};
          state_d = HIGH;
        end else if (tmo_q != '0 && cnt_q != tmo_q) begin
          // Runs only for the stuck check; parks once it reaches timeout.
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == tmo_q) begin
            stuck_d = 1'b1;
            slvl_d  = lvl_raw;
          end
        end
      end
      default: begin // HIGH, LOW
        if (!en_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (tmo_q != '0 && cnt_q == tmo_q) begin
          stuck_d = 1'b1;
          slvl_d  = lvl_raw;
          state_d = ARM;
          cnt_d   = '0;
        end else if (cnt_q == '1) begin
          ovf_d   = 1'b1;
          state_d = ARM;
          cnt_d   = '0;
        end else if (state_q == HIGH && fall) begin
          hcnt_d  = cnt_q;
          cnt_d   = cnt_q + 1'b1;
          state_d = LOW;
        end else if (state_q == LOW && rise) begin
          period_d = cnt_q;
          high_d   = hcnt_q;
          dc_d     = hcnt_q;
          vdc_d    = 1'b1;
          valid_d  = 1'b1;
          cnt_d    = {{(CW-1){1'b0}}, 1'b1};
          if (cont_q) state_d = HIGH;
          else begin
            en_d    = 1'b0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase

    // Soft reset: ctrl, FSM, counters and status cleared; timeout kept.
    if (wr_ctrl && i_wb_data[7]) begin
      srst_d  = 1'b1;
      en_d    = 1'b0;
      cont_d  = 1'b0;
      inv_d   = 1'b0;
      state_d = IDLE;
      cnt_d   = '0;
      hcnt_d  = '0;
      vdc_d   = 1'b0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
      stuck_d = 1'b0;
      slvl_d  = 1'b0;
`ifdef PWM_CAPTURE_IRQ_EN
      irq_en_d = 1'b0;
`endif
    end
  end

  // State and register flops.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q  <= IDLE;
      sync_q   <= '0;
      prev_q   <= 1'b0;
      cnt_q    <= '0;
      hcnt_q   <= '0;
      period_q <= '0;
      high_q   <= '0;
      tmo_q    <= '0;
      dc_q     <= '0;
      vdc_q    <= 1'b0;
      en_q     <= 1'b0;
      cont_q   <= 1'b0;
      inv_q    <= 1'b0;
      srst_q   <= 1'b0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      stuck_q  <= 1'b0;
      slvl_q   <= 1'b0;
`ifdef PWM_CAPTURE_IRQ_EN
      irq_en_q <= 1'b0;
      int_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      hcnt_q   <= hcnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      tmo_q    <= tmo_d;
      dc_q     <= dc_d;
      vdc_q    <= vdc_d;
      en_q     <= en_d;
      cont_q   <= cont_d;
      inv_q    <= inv_d;
      srst_q   <= srst_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      stuck_q  <= stuck_d;
      slvl_q   <= slvl_d;
`ifdef PWM_CAPTURE_IRQ_EN
      irq_en_q <= irq_en_d;
      int_q    <= int_d;
`endif
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: random and directed pulse trains; expected duty words are
// queued when the closing rising edge is driven and a monitor pops them on
// every o_valid_DC strobe.
module tb_pwm_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [15:0] adr = '0, wdat = '0, rdat;
  logic        ack;
  logic        pwm = 1'b0;
  logic [15:0] dc;
  logic        vdc;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int last_per, last_high;
  logic [15:0] rv;

  pwm_capture dut (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb),
    .i_wb_we(we), .i_wb_adr(adr), .i_wb_data(wdat), .o_wb_data(rdat),
    .o_wb_ack(ack), .i_pwm(pwm), .o_DC(dc), .o_valid_DC(vdc)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every duty strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && vdc) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_valid: got o_DC=%0d with no capture expected", dc);
      end else begin
        check("o_DC", {16'h0, dc}, exp_q.pop_front());
      end
    end
  end

  // All bus tasks start and end at a falling edge.
  task automatic wb_write(input logic [15:0] a, input logic [15:0] d);
    cyc = 1; stb = 1; we = 1; adr = a; wdat = d;
    @(posedge clk);
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
  endtask

  task automatic wb_read(input logic [15:0] a, output logic [15:0] d);
    cyc = 1; stb = 1; we = 0; adr = a;
    #1;
    d = rdat;
    check("ack", {31'h0, ack}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    cyc = 0; stb = 0;
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input logic [15:0] mask,
                        input logic [15:0] exp);
    logic [15:0] d;
    wb_read(a, d);
    check(name, {16'h0, d & mask}, {16'h0, exp});
  endtask

  task automatic pulse(input int h, input int l);
    pwm = 1'b1;
    repeat (h) @(negedge clk);
    pwm = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  // n+1 pulses: each rising edge after the first closes the previous pulse.
  task automatic seg(input int n, input int fh, input int fl);
    int h, l, ph, pp;
    ph = 0; pp = 0;
    for (int k = 0; k <= n; k++) begin
      h = (fh != 0) ? fh : int'($urandom_range(1, 40));
      l = (fl != 0) ? fl : int'($urandom_range(1, 40));
      if (k > 0) begin
        exp_q.push_back(ph);
        last_per  = pp;
        last_high = ph;
      end
      ph = h;
      pp = h + l;
      pulse(h, l);
    end
    repeat (10) @(negedge clk);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_o_DC", {16'h0, dc}, 32'h0);
    check("rst_o_valid", {31'h0, vdc}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("rst_ctrl",    16'h0, 16'hFFFF, 16'h0);
    rd_chk("rst_status",  16'h2, 16'hFFFF, 16'h0);
    rd_chk("rst_period",  16'h4, 16'hFFFF, 16'h0);
    rd_chk("rst_high",    16'h6, 16'hFFFF, 16'h0);
    rd_chk("rst_timeout", 16'h8, 16'hFFFF, 16'h0);
    rd_chk("unmapped",    16'hA, 16'hFFFF, 16'h0);

    // Continuous 10/3
    wb_write(16'h0, 16'h0003);
    seg(5, 3, 7);
    check("q_empty_fixed", exp_q.size(), 0);
    rd_chk("period_10", 16'h4, 16'hFFFF, 16'd10);
    rd_chk("high_3",    16'h6, 16'hFFFF, 16'd3);
    rd_chk("valid_set", 16'h2, 16'h0007, 16'h1);
    wb_write(16'h2, 16'h0001);
    rd_chk("valid_w1c", 16'h2, 16'h0007, 16'h0);
    wb_write(16'h4, 16'h1234);
    rd_chk("period_ro", 16'h4, 16'hFFFF, 16'd10);
    wb_write(16'h0, 16'h0000);

    // Random continuous trains
    for (int r = 0; r < 3; r++) begin
      wb_write(16'h0, 16'h0003);
      seg(8, 0, 0);
      wb_write(16'h0, 16'h0000);
      check("q_empty_rand", exp_q.size(), 0);
      rd_chk("period_rand", 16'h4, 16'hFFFF, last_per[15:0]);
      rd_chk("high_rand",   16'h6, 16'hFFFF, last_high[15:0]);
    end

    // One-shot 20/15
    wb_write(16'h2, 16'h0007);
    wb_write(16'h0, 16'h0001);
    pulse(15, 5);
    exp_q.push_back(15);
    pulse(15, 5);
    pulse(15, 5);
    pulse(15, 5);
    repeat (10) @(negedge clk);
    check("q_empty_oneshot", exp_q.size(), 0);
    rd_chk("oneshot_en_clr", 16'h0, 16'hFFFF, 16'h0);
    rd_chk("period_20",      16'h4, 16'hFFFF, 16'd20);
    rd_chk("high_15",        16'h6, 16'hFFFF, 16'd15);

    // Stuck high with timeout 100
    wb_write(16'h2, 16'h0007);
    wb_write(16'h8, 16'd100);
    wb_write(16'h0, 16'h0003);
    pwm = 1'b1;
    repeat (60) @(negedge clk);
    rd_chk("stuck_early", 16'h2, 16'hFFFF, 16'h0);
    repeat (70) @(negedge clk);
    rd_chk("stuck_set", 16'h2, 16'hFFFF, 16'hC);
    wb_write(16'h2, 16'h0004);
    rd_chk("stuck_w1c", 16'h2, 16'hFFFF, 16'h8);
    pwm = 1'b0;
    wb_write(16'h0, 16'h0000);
    wb_write(16'h8, 16'h0000);

    // Overflow: 70000-cycle high phase
    wb_write(16'h2, 16'h0007);
    wb_write(16'h0, 16'h0003);
    pwm = 1'b1;
    repeat (70000) @(negedge clk);
    rd_chk("ovf_set",       16'h2, 16'h0007, 16'h2);
    rd_chk("ovf_period_kp", 16'h4, 16'hFFFF, 16'd20);
    rd_chk("ovf_high_kp",   16'h6, 16'hFFFF, 16'd15);
    pwm = 1'b0;
    repeat (10) @(negedge clk);
    pulse(4, 6);
    exp_q.push_back(4);
    pulse(2, 5);
    repeat (10) @(negedge clk);
    check("q_empty_ovf", exp_q.size(), 0);
    rd_chk("ovf_resume_per", 16'h4, 16'hFFFF, 16'd10);
    wb_write(16'h0, 16'h0000);

    // W1C of valid in the capture cycle: the set wins
    wb_write(16'h2, 16'h0007);
    wb_write(16'h0, 16'h0003);
    pulse(3, 5);
    exp_q.push_back(3);
    pwm = 1'b1;
    @(negedge clk);
    @(negedge clk);
    wb_write(16'h2, 16'h0001);
    pwm = 1'b0;
    repeat (5) @(negedge clk);
    check("q_empty_race", exp_q.size(), 0);
    rd_chk("valid_set_wins", 16'h2, 16'h0001, 16'h1);
    wb_write(16'h0, 16'h0000);

    // Soft reset keeps timeout
    wb_write(16'h8, 16'd55);
    wb_write(16'h0, 16'h0083);
    rd_chk("srst_timeout", 16'h8, 16'hFFFF, 16'd55);
    rd_chk("srst_status",  16'h2, 16'hFFFF, 16'h0);
    rd_chk("srst_ctrl",    16'h0, 16'hFFFF, 16'h0);

    // Hard reset in the middle of a LOW phase
    wb_write(16'h0, 16'h0003);
    pulse(3, 4);
    rst_n = 1'b0;
    #1;
    check("hrst_o_DC", {16'h0, dc}, 32'h0);
    check("hrst_valid", {31'h0, vdc}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_chk("hrst_ctrl",    16'h0, 16'hFFFF, 16'h0);
    rd_chk("hrst_status",  16'h2, 16'hFFFF, 16'h0);
    rd_chk("hrst_period",  16'h4, 16'hFFFF, 16'h0);
    rd_chk("hrst_high",    16'h6, 16'hFFFF, 16'h0);
    rd_chk("hrst_timeout", 16'h8, 16'hFFFF, 16'h0);
    check("q_empty_end", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
